// File: rtl/tick_ctrl_gen.sv
// Front-end timing/control for the down-counter: button synchronizer, debouncer,
// run/pause toggle FSM and a prescaler producing a one-cycle count-enable tick.
module tick_ctrl_gen #(
  parameter int DIV       = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic tick,
  output logic btn_level,
  output logic btn_pulse,
  output logic running
);

  localparam int DIV_W = $clog2(DIV);
  localparam int DB_W  = $clog2(DB_CYCLES);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_CYCLES - 1);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  logic [1:0]       sync_q;
  logic             btn_sync;
  logic [DB_W-1:0]  db_cnt;
  logic [DIV_W-1:0] div_cnt;
  run_state_t       state, state_nxt;

  // Synchronizer flops reset to the released (high) level so no phantom press
  // is seen coming out of reset.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values and the shift chain cannot collapse into one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], btn_n};
  end

  assign btn_sync = ~sync_q[1];

  // The level only follows btn_sync after it has disagreed for DB_CYCLES
  // consecutive edges; the press strobe is raised on the same edge as the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_pulse <= 1'b0;
      if (btn_sync == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        btn_level <= btn_sync;
        btn_pulse <= btn_sync;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PAUSED;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    running   = 1'b0;
    case (state)
      PAUSED: begin
        if (btn_pulse) state_nxt = RUNNING;
      end
      RUNNING: begin
        running = 1'b1;
        if (btn_pulse) state_nxt = PAUSED;
      end
      default: state_nxt = PAUSED;
    endcase
  end

  // Counter holds while paused so a resume continues the interrupted period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (running) begin
      if (div_cnt == DIV_MAX) begin
        div_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_ctrl_gen.sv
// Directed bench for tick_ctrl_gen (DIV=4, DB_CYCLES=3): expected strobe edges are
// queued by the stimulus and consumed by a monitor whenever tick/btn_pulse fire.
module tb_tick_ctrl_gen;

  localparam int DIV       = 4;
  localparam int DB_CYCLES = 3;

  logic clk = 1'b0;
  logic rst;
  logic btn_n;
  logic tick;
  logic btn_level;
  logic btn_pulse;
  logic running;

  int edge_cnt = 0;
  int n_checks = 0;
  int errors   = 0;
  int tick_q[$];
  int pulse_q[$];

  int k1, k2, k3, k4, k5, base;

  tick_ctrl_gen #(
    .DIV       (DIV),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .tick      (tick),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .running   (running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Called at a negedge; returns at the negedge following edge n.
  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (edge_cnt < n) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        check("wait_edge_timeout", edge_cnt, n);
        return;
      end
    end
  endtask

  // Button goes low so that it is first sampled at edge k; released after edge k+5.
  task automatic press_at(input int k);
    wait_edge(k - 1);
    btn_n = 1'b0;
    pulse_q.push_back(k + 4);
    wait_edge(k + 5);
    btn_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (btn_pulse) begin
      if (pulse_q.size() == 0) check("unexpected_pulse_at_edge", edge_cnt, -1);
      else                     check("pulse_edge", edge_cnt, pulse_q.pop_front());
    end
    if (tick) begin
      if (tick_q.size() == 0) check("unexpected_tick_at_edge", edge_cnt, -1);
      else                    check("tick_edge", edge_cnt, tick_q.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    btn_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_tick", tick, 0);
    check("reset_btn_level", btn_level, 0);
    check("reset_btn_pulse", btn_pulse, 0);
    check("reset_running", running, 0);
    rst = 1'b0;

    base = edge_cnt;
    wait_edge(base + 20);
    check("idle_tick", tick, 0);
    check("idle_running", running, 0);

    for (int i = 0; i < 20; i++) begin
      btn_n = ((i / 2) % 2 != 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      check("bounce_btn_level", btn_level, 0);
      check("bounce_running", running, 0);
    end
    btn_n = 1'b1;
    base = edge_cnt;
    wait_edge(base + 10);
    check("post_bounce_btn_level", btn_level, 0);
    check("post_bounce_running", running, 0);

    // Clean press: level/pulse after k+4, running after k+5, ticks every 4 from k+9.
    k1 = edge_cnt + 1;
    pulse_q.push_back(k1 + 4);
    for (int j = 0; j < 4; j++) tick_q.push_back(k1 + 9 + 4 * j);
    btn_n = 1'b0;
    wait_edge(k1 + 3);
    check("press_level_not_early", btn_level, 0);
    wait_edge(k1 + 4);
    check("press_level", btn_level, 1);
    check("press_running_not_early", running, 0);
    wait_edge(k1 + 5);
    check("press_running", running, 1);
    check("press_div_cnt_start", int'(dut.div_cnt), 0);
    wait_edge(k1 + 6);
    btn_n = 1'b1;

    // Second press pauses with div_cnt = 2 (running fell after k1+23).
    k2 = k1 + 18;
    press_at(k2);
    check("pause_running", running, 0);
    check("pause_div_cnt", int'(dut.div_cnt), 2);
    wait_edge(k2 + 5 + 50);
    check("paused_running", running, 0);
    check("paused_div_cnt_held", int'(dut.div_cnt), 2);

    // Resume: first tick two edges after running rises.
    k3 = k2 + 60;
    press_at(k3);
    check("resume_running", running, 1);
    check("resume_div_cnt", int'(dut.div_cnt), 2);
    for (int j = 0; j < 5; j++) tick_q.push_back(k3 + 7 + 4 * j);

    // Pause strobe lands on the div_cnt = 3 cycle: final tick and PAUSED together.
    k4 = k3 + 18;
    press_at(k4);
    check("wrap_pause_tick", tick, 1);
    check("wrap_pause_running", running, 0);
    check("wrap_pause_div_cnt", int'(dut.div_cnt), 0);
    wait_edge(k4 + 25);
    check("after_wrap_running", running, 0);
    check("after_wrap_tick_q_empty", tick_q.size(), 0);

    // Async reset mid-period.
    k5 = edge_cnt + 1;
    press_at(k5);
    check("run5_running", running, 1);
    wait_edge(k5 + 7);
    check("pre_reset_div_cnt", int'(dut.div_cnt), 2);
    check("pre_reset_running", running, 1);
    check("pre_reset_btn_level", btn_level, 1);
    #1 rst = 1'b1;
    #1;
    check("async_reset_running", running, 0);
    check("async_reset_tick", tick, 0);
    check("async_reset_div_cnt", int'(dut.div_cnt), 0);
    check("async_reset_btn_level", btn_level, 0);
    @(negedge clk);
    rst = 1'b0;
    base = edge_cnt;
    wait_edge(base + 20);
    check("post_reset_running", running, 0);
    check("post_reset_tick", tick, 0);
    check("final_pulse_q_empty", pulse_q.size(), 0);
    check("final_tick_q_empty", tick_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
